// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - parity modes and receiver FSM encoding shared by the UART receiver files
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

endpackage

// File: rtl/uart_bit_sampler.sv
// rtl/uart_bit_sampler.sv - line synchroniser, falling-edge detect, baud counter and 3-sample bit vote
module uart_bit_sampler
  import uart_pkg::*;
#(
  parameter int CLK_FREQ    = 50000000,
  parameter int UART_BPS    = 115200,
  parameter int SYNC_STAGES = 2
) (
  input  logic rx_clk,
  input  logic rst_n,
  input  logic uart_rxd,
  input  logic active,
  input  logic restart,
  output logic rxs,
  output logic start_edge,
  output logic bit_val,
  output logic bit_strobe,
  output logic bit_end
);

  localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int CW           = $clog2(BAUD_CNT_MAX);
  localparam int MID          = BAUD_CNT_MAX / 2 - 1;
  localparam logic [CW-1:0] CNT_S0   = CW'(MID - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(MID);
  localparam logic [CW-1:0] CNT_VOTE = CW'(MID + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_CNT_MAX - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rxs_prev_q, rxs_prev_d;
  logic [CW-1:0]          baud_cnt_q, baud_cnt_d;
  logic [1:0]             samp_q, samp_d;

  assign rxs = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], uart_rxd};
    rxs_prev_d = rxs;
    baud_cnt_d = '0;
    if (restart)
      baud_cnt_d = '0;
    else if (active)
      baud_cnt_d = (baud_cnt_q == CNT_LAST) ? '0 : baud_cnt_q + 1'b1;
    samp_d = samp_q;
    if (active && baud_cnt_q == CNT_S0) samp_d[0] = rxs;
    if (active && baud_cnt_q == CNT_S1) samp_d[1] = rxs;
  end

  // third sample is the live line at MID+1, so the vote is ready that same cycle
  assign bit_val    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs) | (samp_q[1] & rxs);
  assign bit_strobe = active && (baud_cnt_q == CNT_VOTE);
  assign bit_end    = active && (baud_cnt_q == CNT_LAST);
  assign start_edge = rxs_prev_q & ~rxs;

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '1;
      rxs_prev_q <= 1'b1;
      baud_cnt_q <= '0;
      samp_q     <= '0;
    end else begin
      sync_q     <= sync_d;
      rxs_prev_q <= rxs_prev_d;
      baud_cnt_q <= baud_cnt_d;
      samp_q     <= samp_d;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable UART receiver: frame FSM, shift register, parity and error flags
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ    = 50000000,
  parameter int UART_BPS    = 115200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 rx_clk,
  input  logic                 rst_n,
  input  logic                 uart_rxd,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det
);

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic                 par_acc_q, par_acc_d;
  logic                 par_bad_q, par_bad_d;
  logic                 par_bit_q, par_bit_d;
  logic                 fe_q, fe_d;
  logic                 armed_q, armed_d;
  logic                 rx_valid_q, rx_valid_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 break_det_q, break_det_d;

  logic rxs, start_edge, bit_val, bit_strobe, bit_end;
  logic restart, is_break;

  assign restart = (state_q == S_IDLE) && start_edge && armed_q;

  uart_bit_sampler #(
    .CLK_FREQ   (CLK_FREQ),
    .UART_BPS   (UART_BPS),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sampler (
    .rx_clk    (rx_clk),
    .rst_n     (rst_n),
    .uart_rxd  (uart_rxd),
    .active    (state_q != S_IDLE),
    .restart   (restart),
    .rxs       (rxs),
    .start_edge(start_edge),
    .bit_val   (bit_val),
    .bit_strobe(bit_strobe),
    .bit_end   (bit_end)
  );

  assign is_break = (shift_q == '0) && !par_bit_q && !bit_val;

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    par_acc_d    = par_acc_q;
    par_bad_d    = par_bad_q;
    par_bit_d    = par_bit_q;
    fe_d         = fe_q;
    armed_d      = armed_q;
    rx_valid_d   = 1'b0;
    rx_data_d    = rx_data_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    break_det_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // after a break the line must be seen high before a new start is accepted
        if (rxs) armed_d = 1'b1;
        if (restart) begin
          state_d   = S_START;
          bit_cnt_d = '0;
          par_acc_d = 1'b0;
          par_bad_d = 1'b0;
          par_bit_d = 1'b0;
          fe_d      = 1'b0;
        end
      end
      S_START: begin
        if (bit_strobe && bit_val) state_d = S_IDLE;
        else if (bit_end)          state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_strobe) begin
          shift_d   = {bit_val, shift_q[DATA_BITS-1:1]};
          par_acc_d = par_acc_q ^ bit_val;
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
        if (bit_end && bit_cnt_q == 4'(DATA_BITS)) begin
          state_d   = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
          bit_cnt_d = '0;
        end
      end
      S_PARITY: begin
        if (bit_strobe) begin
          par_bit_d = bit_val;
          par_bad_d = (PARITY == PAR_ODD) ? ~(par_acc_q ^ bit_val) : (par_acc_q ^ bit_val);
        end
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_strobe) begin
          if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
            state_d      = S_IDLE;
            rx_valid_d   = 1'b1;
            rx_data_d    = shift_q;
            parity_err_d = par_bad_q;
            frame_err_d  = fe_q | ~bit_val;
            break_det_d  = is_break;
            if (is_break) armed_d = 1'b0;
          end else begin
            fe_d      = fe_q | ~bit_val;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      par_acc_q    <= 1'b0;
      par_bad_q    <= 1'b0;
      par_bit_q    <= 1'b0;
      fe_q         <= 1'b0;
      armed_q      <= 1'b0;
      rx_valid_q   <= 1'b0;
      rx_data_q    <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      break_det_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      par_acc_q    <= par_acc_d;
      par_bad_q    <= par_bad_d;
      par_bit_q    <= par_bit_d;
      fe_q         <= fe_d;
      armed_q      <= armed_d;
      rx_valid_q   <= rx_valid_d;
      rx_data_q    <= rx_data_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      break_det_q  <= break_det_d;
    end
  end

  assign rx_valid   = rx_valid_q;
  assign rx_data    = rx_data_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign break_det  = break_det_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - directed frames into 8N1, 8E1 and 5N2 receivers with a per-lane capture log
module tb_uart_rx_cfg;

  localparam int BIT = 434;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] rxd;

  logic       v0, v1, v2;
  logic [7:0] d0, d1;
  logic [4:0] d2;
  logic       pe0, pe1, pe2, fe0, fe1, fe2, bk0, bk1, bk2;

  always #10 clk = ~clk;

  uart_rx_cfg #(.CLK_FREQ(50000000), .UART_BPS(115200), .DATA_BITS(8), .PARITY(0),
                .STOP_BITS(1), .SYNC_STAGES(2)) u_8n1 (
    .rx_clk(clk), .rst_n(rst_n), .uart_rxd(rxd[0]), .rx_valid(v0), .rx_data(d0),
    .parity_err(pe0), .frame_err(fe0), .break_det(bk0));

  uart_rx_cfg #(.CLK_FREQ(50000000), .UART_BPS(115200), .DATA_BITS(8), .PARITY(2),
                .STOP_BITS(1), .SYNC_STAGES(2)) u_8e1 (
    .rx_clk(clk), .rst_n(rst_n), .uart_rxd(rxd[1]), .rx_valid(v1), .rx_data(d1),
    .parity_err(pe1), .frame_err(fe1), .break_det(bk1));

  uart_rx_cfg #(.CLK_FREQ(50000000), .UART_BPS(115200), .DATA_BITS(5), .PARITY(0),
                .STOP_BITS(2), .SYNC_STAGES(2)) u_5n2 (
    .rx_clk(clk), .rst_n(rst_n), .uart_rxd(rxd[2]), .rx_valid(v2), .rx_data(d2),
    .parity_err(pe2), .frame_err(fe2), .break_det(bk2));

  int         total = 0;
  int         bad = 0;
  int         cnt [3];
  logic [8:0] rec_d [3][64];
  logic [2:0] rec_f [3][64];

  always @(negedge clk) begin
    if (v0) begin rec_d[0][cnt[0] & 63] = {1'b0, d0}; rec_f[0][cnt[0] & 63] = {pe0, fe0, bk0}; cnt[0]++; end
    if (v1) begin rec_d[1][cnt[1] & 63] = {1'b0, d1}; rec_f[1][cnt[1] & 63] = {pe1, fe1, bk1}; cnt[1]++; end
    if (v2) begin rec_d[2][cnt[2] & 63] = {4'b0, d2}; rec_f[2][cnt[2] & 63] = {pe2, fe2, bk2}; cnt[2]++; end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // pe/fe/bk packed as {parity_err, frame_err, break_det}
  task automatic check_rx(input int lane, input int idx, input string tag,
                          input logic [8:0] d, input logic [2:0] flags);
    chk({tag, "_data"}, 32'(rec_d[lane][idx & 63]), 32'(d));
    chk({tag, "_flags"}, 32'(rec_f[lane][idx & 63]), 32'(flags));
  endtask

  function automatic logic [15:0] frame(input logic [8:0] d, input int nd, input int np,
                                        input logic pb, input int ns, input logic sv);
    logic [15:0] b;
    int k;
    b = '1;
    b[0] = 1'b0;
    k = 1;
    for (int i = 0; i < nd; i++) begin b[k] = d[i]; k++; end
    if (np != 0) begin b[k] = pb; k++; end
    for (int i = 0; i < ns; i++) begin b[k] = sv; k++; end
    return b;
  endfunction

  task automatic send(input int lane, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rxd[lane] = bits[i];
      repeat (BIT) @(negedge clk);
    end
    rxd[lane] = 1'b1;
  endtask

  int          c;
  logic [15:0] fb;

  initial begin
    rxd   = 3'b111;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_valid", 32'(v0), 32'h0);
    chk("rst_data", 32'(d0), 32'h0);
    chk("rst_flags", 32'({pe0, fe0, bk0}), 32'h0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // back-to-back 8N1 frames
    c = cnt[0];
    send(0, frame(9'h55, 8, 0, 1'b0, 1, 1'b1), 10);
    send(0, frame(9'hA3, 8, 0, 1'b0, 1, 1'b1), 10);
    repeat (20) @(negedge clk);
    chk("t1_count", 32'(cnt[0] - c), 32'd2);
    check_rx(0, c, "t1_a", 9'h55, 3'b000);
    check_rx(0, c + 1, "t1_b", 9'hA3, 3'b000);

    // even parity: A3 has four ones, so parity bit 0 is correct
    c = cnt[1];
    send(1, frame(9'hA3, 8, 1, 1'b0, 1, 1'b1), 11);
    send(1, frame(9'hA3, 8, 1, 1'b1, 1, 1'b1), 11);
    repeat (20) @(negedge clk);
    chk("t2_count", 32'(cnt[1] - c), 32'd2);
    check_rx(1, c, "t2_ok", 9'hA3, 3'b000);
    check_rx(1, c + 1, "t2_bad", 9'hA3, 3'b100);

    // stop bit low, data nonzero: framing error without break
    c = cnt[0];
    send(0, frame(9'h3C, 8, 0, 1'b0, 1, 1'b0), 10);
    repeat (BIT) @(negedge clk);
    chk("t3_count", 32'(cnt[0] - c), 32'd1);
    check_rx(0, c, "t3", 9'h3C, 3'b010);

    // short low glitch is a false start
    c = cnt[0];
    rxd[0] = 1'b0;
    repeat (100) @(negedge clk);
    rxd[0] = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    chk("t4_glitch", 32'(cnt[0] - c), 32'd0);
    send(0, frame(9'h81, 8, 0, 1'b0, 1, 1'b1), 10);
    repeat (20) @(negedge clk);
    chk("t4_count", 32'(cnt[0] - c), 32'd1);
    check_rx(0, c, "t4", 9'h81, 3'b000);

    // break: 20 bit times low
    c = cnt[0];
    rxd[0] = 1'b0;
    repeat (20 * BIT) @(negedge clk);
    rxd[0] = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    chk("t5_count", 32'(cnt[0] - c), 32'd1);
    check_rx(0, c, "t5_brk", 9'h00, 3'b011);
    send(0, frame(9'h7E, 8, 0, 1'b0, 1, 1'b1), 10);
    repeat (20) @(negedge clk);
    chk("t5_count2", 32'(cnt[0] - c), 32'd2);
    check_rx(0, c + 1, "t5_next", 9'h7E, 3'b000);

    // reset during data bit 4 of 0xF0
    c  = cnt[0];
    fb = frame(9'hF0, 8, 0, 1'b0, 1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      rxd[0] = fb[i];
      repeat (BIT) @(negedge clk);
    end
    rxd[0] = fb[5];
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_data", 32'(d0), 32'h0);
    chk("t6_rst_valid", 32'(v0), 32'h0);
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 5; i < 10; i++) begin
      rxd[0] = fb[i];
      repeat (BIT) @(negedge clk);
    end
    repeat (BIT) @(negedge clk);
    chk("t6_discard", 32'(cnt[0] - c), 32'd0);
    send(0, frame(9'h12, 8, 0, 1'b0, 1, 1'b1), 10);
    repeat (20) @(negedge clk);
    chk("t6_count", 32'(cnt[0] - c), 32'd1);
    check_rx(0, c, "t6", 9'h12, 3'b000);

    // 5 data bits, 2 stop bits
    c = cnt[2];
    send(2, frame(9'h1F, 5, 0, 1'b0, 2, 1'b1), 8);
    repeat (20) @(negedge clk);
    chk("t7_count", 32'(cnt[2] - c), 32'd1);
    check_rx(2, c, "t7", 9'h1F, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
